// File: rtl/nfc_poll_pkg.sv
// Shared types and constants for the NFC Read Status poller.
// Holds FSM states, status byte bit positions and default IDs.
package nfc_poll_pkg;

    localparam int IdleIdx   = 0;
    localparam int SelectIdx = 1;
    localparam int IssueIdx  = 2;
    localparam int WaitIdx   = 3;
    localparam int GapIdx    = 4;

    typedef enum logic [4:0] {
        sIdle     = 5'b00001,
        sSelect   = 5'b00010,
        sIssue    = 5'b00100,
        sWaitLast = 5'b01000,
        sGap      = 5'b10000
    } pollState_t;

    localparam int RdyBit  = 6;
    localparam int ArdyBit = 5;
    localparam int FailBit = 0;

    localparam logic [5:0] DefOpcode = 6'b000111;
    localparam logic [4:0] DefTarget = 5'b00100;

    function automatic logic [15:0] effGap(
        input logic [15:0] gap
    );
        return (gap == 16'd0) ? 16'd1 : gap;
    endfunction

endpackage

// File: rtl/nfc_status_poller_if.sv
// Command/status link between the poller and the Read Status block.
// master: poller (drives command); slave: Read Status block.
interface nfc_status_poller_if #(
    parameter int NumberOfWays = 4
);
    logic [5:0]              oOpcode;
    logic [4:0]              oTargetID;
    logic                    oCMDValid;
    logic                    iCMDReady;
    logic [NumberOfWays-1:0] oWaySelect;
    logic [23:0]             oRowAddress;
    logic [23:0]             iStatus;
    logic                    iStatusValid;
    logic                    iLastStep;

    modport master (
        output oOpcode, oTargetID, oCMDValid,
        output oWaySelect, oRowAddress,
        input  iCMDReady, iStatus, iStatusValid,
        input  iLastStep
    );

    modport slave (
        input  oOpcode, oTargetID, oCMDValid,
        input  oWaySelect, oRowAddress,
        output iCMDReady, iStatus, iStatusValid,
        output iLastStep
    );
endinterface

// File: rtl/nfc_rr_pick.sv
// Combinational round-robin picker: first set bit at/after pointer.
// Ports: iPending mask, iPointer index -> oGrant one-hot, oGrantIdx.
module nfc_rr_pick #(
    parameter int NumberOfWays = 4,
    parameter int PtrW         = 2
) (
    input  logic [NumberOfWays-1:0] iPending,
    input  logic [PtrW-1:0]         iPointer,
    output logic [NumberOfWays-1:0] oGrant,
    output logic [PtrW-1:0]         oGrantIdx
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        oGrant    = '0;
        oGrantIdx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NumberOfWays; i++) begin
            idx = PtrW'((int'(iPointer) + i) % NumberOfWays);
            if (!found && iPending[idx]) begin
                found       = 1'b1;
                oGrant[idx] = 1'b1;
                oGrantIdx   = idx;
            end
        end
    end

endmodule

// File: rtl/nfc_status_poller.sv
// Polls busy ways via Read Status and tracks per-way RDY/FAIL flags.
// Ports: poll/hold/clear in, way flags + result out, rsBus to block.
module nfc_status_poller
    import nfc_poll_pkg::*;
#(
    parameter int          NumberOfWays = 4,
    parameter logic [5:0]  CommandID    = DefOpcode,
    parameter logic [4:0]  TargetID     = DefTarget,
    parameter logic [15:0] PollGap      = 16'd64,
    parameter logic [15:0] Watchdog     = 16'd1023
) (
    input  logic                    iSystemClock,
    input  logic                    iReset_n,
    input  logic [NumberOfWays-1:0] iPollRequest,
    input  logic                    iHold,
    input  logic [NumberOfWays-1:0] iClearFail,
    output logic [NumberOfWays-1:0] oWayReady,
    output logic [NumberOfWays-1:0] oWayFail,
    output logic                    oTimeout,
    output logic                    oBusy,
    output logic                    oResultValid,
    output logic [NumberOfWays-1:0] oResultWay,
    output logic [7:0]              oResultByte,
    nfc_status_poller_if.master     rsBus
);

    localparam int PtrW =
        (NumberOfWays > 1) ? $clog2(NumberOfWays) : 1;

    pollState_t rState, sNext;

    logic [NumberOfWays-1:0] rPending;
    logic [NumberOfWays-1:0] rSel;
    logic [PtrW-1:0]         rSelIdx;
    logic [PtrW-1:0]         rPtr;
    logic [PtrW-1:0]         nextPtr;
    logic [15:0]             rGapCnt;
    logic [15:0]             rWdCnt;

    logic [NumberOfWays-1:0] grant;
    logic [PtrW-1:0]         grantIdx;

    logic cmdValid;
    logic accept;
    logic capture;
    logic wdExpire;
    logic gapDone;
    logic pollEnd;
    logic rdyHit;
    logic failHit;
    logic [NumberOfWays-1:0] wayRdySet;
    logic [NumberOfWays-1:0] wayFailSet;
    logic unusedStatusHi;

    nfc_rr_pick #(
        .NumberOfWays (NumberOfWays),
        .PtrW         (PtrW)
    ) uPick (
        .iPending  (rPending),
        .iPointer  (rPtr),
        .oGrant    (grant),
        .oGrantIdx (grantIdx)
    );

    assign accept   = cmdValid & rsBus.iCMDReady;
    assign capture  = rState[WaitIdx] & rsBus.iStatusValid;
    // A last step in the expiry cycle is a normal completion.
    assign wdExpire = rState[WaitIdx] & ~rsBus.iLastStep
                    & (rWdCnt == Watchdog - 16'd1);
    assign pollEnd  = rState[WaitIdx]
                    & (rsBus.iLastStep | wdExpire);
    assign gapDone  = rGapCnt == effGap(PollGap) - 16'd1;

    assign rdyHit     = capture & rsBus.iStatus[RdyBit];
    assign failHit    = rdyHit & rsBus.iStatus[FailBit];
    assign wayRdySet  = rdyHit  ? rSel : '0;
    assign wayFailSet = failHit ? rSel : '0;

    assign nextPtr = (rSelIdx == PtrW'(NumberOfWays - 1))
                   ? '0 : rSelIdx + PtrW'(1);

    assign unusedStatusHi = ^rsBus.iStatus[23:8];

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) rState <= sIdle;
        else           rState <= sNext;
    end

    always_comb begin
        sNext    = rState;
        cmdValid = 1'b0;
        unique case (1'b1)
            rState[IdleIdx]:
                if (|rPending && !iHold) sNext = sSelect;
            rState[SelectIdx]:
                sNext = sIssue;
            rState[IssueIdx]: begin
                cmdValid = 1'b1;
                if (accept) sNext = sWaitLast;
            end
            rState[WaitIdx]:
                if (pollEnd) sNext = sGap;
            rState[GapIdx]:
                if (gapDone) sNext = sIdle;
            default:
                sNext = sIdle;
        endcase
    end

    assign oBusy             = rState != sIdle;
    assign rsBus.oCMDValid   = cmdValid;
    assign rsBus.oOpcode     = cmdValid ? CommandID : '0;
    assign rsBus.oTargetID   = cmdValid ? TargetID  : '0;
    assign rsBus.oWaySelect  = rSel;
    assign rsBus.oRowAddress = '0;

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            rPending     <= '0;
            rSel         <= '0;
            rSelIdx      <= '0;
            rPtr         <= '0;
            rGapCnt      <= '0;
            rWdCnt       <= '0;
            oWayReady    <= '0;
            oWayFail     <= '0;
            oTimeout     <= 1'b0;
            oResultValid <= 1'b0;
            oResultWay   <= '0;
            oResultByte  <= '0;
        end else begin
            oResultValid <= 1'b0;
            oTimeout     <= 1'b0;
            // A fresh request outranks a same-cycle RDY report.
            rPending  <= (rPending & ~wayRdySet) | iPollRequest;
            oWayReady <= (oWayReady | wayRdySet) & ~iPollRequest;
            oWayFail  <= (oWayFail & ~iClearFail) | wayFailSet;
            // Counters sit at zero outside their state.
            rWdCnt  <= rState[WaitIdx] ? rWdCnt + 16'd1 : '0;
            rGapCnt <= rState[GapIdx]  ? rGapCnt + 16'd1 : '0;
            if (rState[SelectIdx]) begin
                rSel    <= grant;
                rSelIdx <= grantIdx;
            end
            if (capture) begin
                oResultValid <= 1'b1;
                oResultWay   <= rSel;
                oResultByte  <= rsBus.iStatus[7:0];
            end
            if (pollEnd) begin
                rPtr <= nextPtr;
                rSel <= '0;
            end
            if (wdExpire) oTimeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nfc_status_poller.sv
// Self-checking bench for nfc_status_poller with a fake Read Status block.
// Table of poll transactions plus hand sequences; results via scoreboard.
module tb_nfc_status_poller;

    logic       clk;
    logic       rstN;
    logic [3:0] iPollRequest;
    logic       iHold;
    logic [3:0] iClearFail;
    logic [3:0] oWayReady;
    logic [3:0] oWayFail;
    logic       oTimeout;
    logic       oBusy;
    logic       oResultValid;
    logic [3:0] oResultWay;
    logic [7:0] oResultByte;

    nfc_status_poller_if #(.NumberOfWays(4)) bus ();

    nfc_status_poller dut (
        .iSystemClock (clk),
        .iReset_n     (rstN),
        .iPollRequest (iPollRequest),
        .iHold        (iHold),
        .iClearFail   (iClearFail),
        .oWayReady    (oWayReady),
        .oWayFail     (oWayFail),
        .oTimeout     (oTimeout),
        .oBusy        (oBusy),
        .oResultValid (oResultValid),
        .oResultWay   (oResultWay),
        .oResultByte  (oResultByte),
        .rsBus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nTotal = 0;
    int nPass  = 0;
    int lastAccept = 0;
    logic [11:0] sb[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // Scoreboard: compare every captured status against the queue.
    always @(negedge clk) begin
        if (rstN && oResultValid) begin
            if (sb.size() == 0) begin
                chk("unexpectedResult", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                chk("resultWay",  oResultWay,  e[11:8]);
                chk("resultByte", oResultByte, e[7:0]);
            end
        end
    end

    // mode 0: status then last; 1: together; 2: last only; 3: neither
    task automatic serve(input logic [3:0] expWay,
                         input logic [7:0] st,
                         input int mode,
                         input int rdyDelay,
                         input logic [3:0] clrWith,
                         input logic [3:0] reqWith);
        int n;
        bit stable;
        n = 0;
        stable = 1'b1;
        while (!bus.oCMDValid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmdValid", bus.oCMDValid, 1);
        chk("waySelect", bus.oWaySelect, expWay);
        chk("cmdIds", {bus.oTargetID, bus.oOpcode},
            {5'b00100, 6'b000111});
        for (int i = 0; i < rdyDelay; i++) begin
            @(negedge clk);
            if (!bus.oCMDValid || bus.oOpcode != 6'b000111
                || bus.oWaySelect != expWay)
                stable = 1'b0;
        end
        if (rdyDelay > 0) chk("cmdHeld", stable, 1);
        bus.iCMDReady = 1'b1;
        @(negedge clk);
        bus.iCMDReady = 1'b0;
        lastAccept = cyc;
        chk("cmdDrop", bus.oCMDValid, 0);
        if (mode == 0 || mode == 1) begin
            bus.iStatus      = {16'hA5C3, st};
            bus.iStatusValid = 1'b1;
            bus.iLastStep    = (mode == 1);
            iClearFail       = clrWith;
            iPollRequest     = reqWith;
            sb.push_back({expWay, st});
            @(negedge clk);
            bus.iStatusValid = 1'b0;
            bus.iLastStep    = 1'b0;
            iClearFail       = '0;
            iPollRequest     = '0;
        end
        if (mode == 0 || mode == 2) begin
            bus.iLastStep = 1'b1;
            @(negedge clk);
            bus.iLastStep = 1'b0;
        end
    endtask

    task automatic pulseReq(input logic [3:0] m);
        iPollRequest = m;
        @(negedge clk);
        iPollRequest = '0;
    endtask

    task automatic waitIdle();
        int n;
        bit quiet;
        n = 0;
        quiet = 1'b1;
        while (oBusy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("busyFalls", oBusy, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oBusy) quiet = 1'b0;
        end
        chk("noRepoll", quiet, 1);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] way;
        logic [7:0] st;
        int         mode;
        int         rdyDelay;
        int         minDelta;
        bit         idleAfter;
        logic [3:0] expRdy;
        logic [3:0] expFail;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n;
        int prev;

        vt[0] = '{4'b1011, 4'b0001, 8'h40, 0, 0, 0,  0, 4'b0001, 4'b0000};
        vt[1] = '{4'b0000, 4'b0010, 8'h40, 1, 0, 0,  0, 4'b0011, 4'b0000};
        vt[2] = '{4'b0000, 4'b1000, 8'h40, 0, 0, 0,  1, 4'b1011, 4'b0000};
        vt[3] = '{4'b0100, 4'b0100, 8'h00, 0, 0, 0,  0, 4'b1011, 4'b0000};
        vt[4] = '{4'b0000, 4'b0100, 8'h00, 2, 0, 65, 0, 4'b1011, 4'b0000};
        vt[5] = '{4'b0000, 4'b0100, 8'h40, 0, 0, 65, 1, 4'b1111, 4'b0000};
        vt[6] = '{4'b0010, 4'b0010, 8'h41, 0, 3, 0,  1, 4'b1111, 4'b0010};

        rstN             = 1'b0;
        iPollRequest     = '0;
        iHold            = 1'b0;
        iClearFail       = '0;
        bus.iCMDReady    = 1'b0;
        bus.iStatus      = '0;
        bus.iStatusValid = 1'b0;
        bus.iLastStep    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rstBusy", oBusy, 0);
        chk("rstCmd", {bus.oCMDValid, bus.oOpcode, bus.oTargetID}, 0);
        chk("rstFlags", {oWayReady, oWayFail, bus.oWaySelect}, 0);
        chk("rstResult", {oResultValid, oTimeout, oResultByte}, 0);
        chk("rstRow", bus.oRowAddress, 0);
        rstN = 1'b1;
        @(negedge clk);
        chk("idleAfterRst", oBusy, 0);

        for (int i = 0; i < 7; i++) begin
            if (vt[i].req != 4'b0000) pulseReq(vt[i].req);
            prev = lastAccept;
            serve(vt[i].way, vt[i].st, vt[i].mode,
                  vt[i].rdyDelay, 4'b0000, 4'b0000);
            if (vt[i].minDelta > 0)
                chk("pollSpacing",
                    (lastAccept - prev) >= vt[i].minDelta, 1);
            @(negedge clk);
            chk("wayReady", oWayReady, vt[i].expRdy);
            chk("wayFail", oWayFail, vt[i].expFail);
            if (vt[i].idleAfter) waitIdle();
        end

        // Sticky FAIL, clear, then FAIL set beats same-cycle clear.
        chk("failSticky", oWayFail, 4'b0010);
        iClearFail = 4'b0010;
        @(negedge clk);
        iClearFail = '0;
        chk("failCleared", oWayFail, 4'b0000);
        pulseReq(4'b0010);
        serve(4'b0010, 8'h41, 0, 0, 4'b0010, 4'b0000);
        chk("failSetWins", oWayFail, 4'b0010);
        waitIdle();

        // Long ready stall.
        pulseReq(4'b0001);
        serve(4'b0001, 8'h40, 0, 20, 4'b0000, 4'b0000);
        chk("stallReady", oWayReady, 4'b1111);
        waitIdle();

        // Watchdog abort, then re-poll of the same way.
        pulseReq(4'b1000);
        serve(4'b1000, 8'h00, 3, 0, 4'b0000, 4'b0000);
        n = 0;
        while (!oTimeout && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("timeoutSeen", oTimeout, 1);
        chk("timeoutCycles", cyc - lastAccept, 1023);
        @(negedge clk);
        chk("timeoutPulse", oTimeout, 0);
        chk("timeoutFlags", {oWayReady, oWayFail}, 8'b0111_0010);
        serve(4'b1000, 8'h40, 0, 0, 4'b0000, 4'b0000);
        chk("repollReady", oWayReady, 4'b1111);
        waitIdle();

        // Reset in WAIT_LAST clears everything at once.
        pulseReq(4'b0001);
        serve(4'b0001, 8'h00, 3, 0, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("preRstBusy", oBusy, 1);
        rstN = 1'b0;
        #1;
        chk("asyncBusy", oBusy, 0);
        chk("asyncCmd", {bus.oCMDValid, bus.oOpcode, bus.oWaySelect}, 0);
        chk("asyncFlags", {oWayReady, oWayFail}, 0);
        chk("asyncResult", {oResultValid, oTimeout}, 0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Request during capture keeps the way pending.
        pulseReq(4'b0100);
        serve(4'b0100, 8'h40, 0, 0, 4'b0000, 4'b0100);
        serve(4'b0100, 8'h40, 0, 0, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("reqKeptReady", oWayReady, 4'b0100);
        waitIdle();

        // Hold blocks new polls.
        iHold = 1'b1;
        pulseReq(4'b0001);
        repeat (10) @(negedge clk);
        chk("holdIdle", oBusy, 0);
        iHold = 1'b0;
        serve(4'b0001, 8'h40, 0, 0, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("holdReady", oWayReady, 4'b0101);
        waitIdle();

        chk("sbDrained", sb.size(), 0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
